bus_deserializer: RTL and testbench



---
 rtl/bus_deserializer.sv | 105 ++++++++++
 tb/tb_bus_deserializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_deserializer.sv
// bus_deserializer: receive side of the 8-bit crypto-accelerator bus.
// Bytes arrive LSB-first over a valid/ready handshake. Every fourth accepted
// byte completes an ADDRW+8-bit transaction word, which is pushed into a
// 2-entry in-order FIFO so bus transfers can continue while the consumer stalls.
module bus_deserializer #(
  parameter int ADDRW = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data_in,
  input  logic               valid_in,
  output logic               bus_ready,
  output logic [ADDRW+7:0]   word_out,
  output logic [ADDRW-1:0]   addr_out,
  output logic [7:0]         byte_out,
  output logic               word_valid,
  input  logic               word_ready
);

  localparam int WORDW = ADDRW + 8;
  // Bytes 0..2 are held in lanes; byte 3 goes straight from data_in to the FIFO.
  localparam int NPART = 3;

  logic [1:0]         cnt_reg;
  logic [8*NPART-1:0] part_word;
  logic [WORDW-1:0]   fifo_mem [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         occ_reg;

  logic fifo_full;
  logic xfer;
  logic push;
  logic pop;

  // Only a completing byte can be blocked; partial bytes always have a lane.
  assign fifo_full  = (occ_reg == 2'd2);
  assign bus_ready  = !((cnt_reg == 2'd3) && fifo_full);
  assign xfer       = valid_in && bus_ready;
  assign push       = xfer && (cnt_reg == 2'd3);
  assign word_valid = (occ_reg != 2'd0);
  assign pop        = word_valid && word_ready;

  // Byte counter: advances once per accepted byte, wraps 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 2'd0;
    end else if (xfer) begin
      cnt_reg <= cnt_reg + 2'd1;
    end
  end

  // One byte lane per partial position; lane gi captures the byte seen at cnt==gi.
  genvar gi;
  generate
    for (gi = 0; gi < NPART; gi++) begin : g_lane
      logic [7:0] lane_reg;

      // Capture this lane's byte when the counter points at it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg <= 8'd0;
        end else if (xfer && (cnt_reg == 2'(gi))) begin
          lane_reg <= data_in;
        end
      end

      assign part_word[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  // FIFO storage: the completing byte is merged with the lanes on the push edge.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {data_in, part_word};
    end
  end

  // FIFO pointers and occupancy; push and pop on one edge leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Head entry is masked to zero when empty so stale storage never leaks out.
  assign word_out = word_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign addr_out = word_out[WORDW-1:8];
  assign byte_out = word_out[7:0];

endmodule

// File: tb/tb_bus_deserializer.sv
// tb_bus_deserializer: directed and random stimulus against a queue-based
// model of the deserializer (byte position arithmetic plus a 2-deep word queue).
module tb_bus_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  data_in = 8'd0;
  logic        valid_in = 1'b0;
  logic        bus_ready;
  logic [31:0] word_out;
  logic [23:0] addr_out;
  logic [7:0]  byte_out;
  logic        word_valid;
  logic        word_ready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_deserializer #(.ADDRW(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .bus_ready (bus_ready),
    .word_out  (word_out),
    .addr_out  (addr_out),
    .byte_out  (byte_out),
    .word_valid(word_valid),
    .word_ready(word_ready)
  );

  // ---------------- behavioural model ----------------
  int          m_cnt = 0;        // bytes collected toward the current word
  logic [31:0] m_part = 32'd0;   // word being assembled
  logic [31:0] m_q[$];           // words waiting for the consumer (max 2)
  logic        m_xfer;
  logic        m_pop;

  function automatic logic m_ready();
    return !(m_cnt == 3 && m_q.size() == 2);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt  = 0;
        m_part = 32'd0;
        m_q.delete();
      end else begin
        m_xfer = valid_in && m_ready();
        m_pop  = word_ready && (m_q.size() != 0);
        if (m_pop) void'(m_q.pop_front());
        if (m_xfer) begin
          m_part[8*m_cnt +: 8] = data_in;
          if (m_cnt == 3) begin
            m_q.push_back(m_part);
            $display("push word %08h", m_part);
          end
          m_cnt = (m_cnt + 1) % 4;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [31:0] pop_log[$];
  logic        cont_phase = 1'b0;
  int          cont_low = 0;

  initial begin
    logic [31:0] exp_word;
    logic        exp_valid;
    forever begin
      @(negedge clk);
      exp_valid = (m_q.size() != 0);
      exp_word  = exp_valid ? m_q[0] : 32'd0;
      check("bus_ready",  {31'd0, bus_ready},  {31'd0, m_ready()});
      check("word_valid", {31'd0, word_valid}, {31'd0, exp_valid});
      check("word_out",   word_out,            exp_word);
      check("addr_out",   {8'd0, addr_out},    {8'd0, exp_word[31:8]});
      check("byte_out",   {24'd0, byte_out},   {24'd0, exp_word[7:0]});
      if (cont_phase && !bus_ready) cont_low++;
      if (rst_n && word_valid && word_ready) begin
        pop_log.push_back(word_out);
        $display("pop word %08h", word_out);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    logic rdy;
    int   guard;
    data_in  = b;
    valid_in = 1'b1;
    guard    = 0;
    forever begin
      rdy = bus_ready;
      tick();
      if (rdy) break;
      guard++;
      if (guard > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout byte=%h actual=stalled required=accepted", b);
        break;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send(w[8*b +: 8]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          base;
    logic [31:0] words[$];
    logic [31:0] w;
    logic [31:0] bp_exp[3];

    bp_exp[0] = 32'h11111111;
    bp_exp[1] = 32'h22222222;
    bp_exp[2] = 32'h33333333;

    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_bus_ready",  {31'd0, bus_ready},  32'd1);
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_word_out",   word_out,            32'd0);
    check("rst_addr_out",   {8'd0, addr_out},    32'd0);
    check("rst_byte_out",   {24'd0, byte_out},   32'd0);
    rst_n = 1'b1;
    tick();

    // single word
    word_ready = 1'b1;
    send(8'hD8); send(8'hC7); send(8'hB6);
    check("sw_no_early_word", {31'd0, word_valid}, 32'd0);
    send(8'hA5);
    check("sw_valid",    {31'd0, word_valid}, 32'd1);
    check("sw_word",     word_out,            32'hA5B6C7D8);
    check("sw_addr",     {8'd0, addr_out},    32'h00A5B6C7);
    check("sw_byte",     {24'd0, byte_out},   32'h000000D8);
    tick();
    check("sw_one_cycle", {31'd0, word_valid}, 32'd0);

    // backpressure: two full words plus three bytes before stalling
    word_ready = 1'b0;
    send_word(32'h11111111);
    send_word(32'h22222222);
    send(8'h33); send(8'h33); send(8'h33);
    base = pop_log.size();
    check("bp_ready_low", {31'd0, bus_ready}, 32'd0);
    data_in  = 8'h33;
    valid_in = 1'b1;
    repeat (2) begin
      tick();
      check("bp_ready_hold", {31'd0, bus_ready}, 32'd0);
    end
    word_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", {31'd0, bus_ready}, 32'd1);
    tick();
    valid_in = 1'b0;
    idle(3);
    check("bp_drained", {31'd0, word_valid}, 32'd0);
    check("bp_pop_count", pop_log.size() - base, 32'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < pop_log.size())
        check("bp_pop_order", pop_log[base + i], bp_exp[i]);

    // gaps inside a frame
    send(8'h01);
    idle(3);
    send(8'h02); send(8'h03);
    idle(1);
    check("gap_no_word", {31'd0, word_valid}, 32'd0);
    send(8'h04);
    check("gap_word", word_out, 32'h04030201);
    tick();

    // asynchronous reset mid-frame
    send(8'hAA); send(8'hBB);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, word_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, bus_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_after_valid", {31'd0, word_valid}, 32'd0);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    check("rst_word", word_out, 32'hDEADBEEF);
    tick();

    // simultaneous push and pop with one word queued
    word_ready = 1'b0;
    send_word(32'hCAFEF00D);
    check("sim_head_before", word_out, 32'hCAFEF00D);
    send(8'h78); send(8'h56); send(8'h34);
    word_ready = 1'b1;
    send(8'h12);
    check("sim_valid", {31'd0, word_valid}, 32'd1);
    check("sim_head_after", word_out, 32'h12345678);
    tick();
    check("sim_occ_one", {31'd0, word_valid}, 32'd0);

    // continuous random stream
    idle(2);
    base = pop_log.size();
    cont_low = 0;
    cont_phase = 1'b1;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      words.push_back(w);
      send_word(w);
    end
    idle(2);
    cont_phase = 1'b0;
    check("cont_ready_low_cycles", cont_low, 32'd0);
    check("cont_pop_count", pop_log.size() - base, 32'd64);
    for (int i = 0; i < 64; i++)
      if (base + i < pop_log.size())
        check("cont_word", pop_log[base + i], words[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
